// File: rtl/pipe_chain_if.sv
// Valid/ready handshake bundle for pipe_chain: upstream (in_*) and downstream (out_*) sides.
interface pipe_chain_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_chain.sv
// N-stage pipeline register chain with valid/ready backpressure, per-stage stall and flush,
// drain mode, registered occupancy and saturating drop/stall statistics.
module pipe_chain #(
  parameter  int unsigned STAGES = 5,
  parameter  int unsigned WIDTH  = 32,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned OCC_W  = $clog2(STAGES + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  pipe_chain_if.slave             bus,
  input  logic [STAGES-1:0]       stall_req,
  input  logic [STAGES-1:0]       flush,
  input  logic                    drain,
  output logic [STAGES-1:0]       stage_valid,
  output logic [STAGES*WIDTH-1:0] stage_data,
  output logic                    empty,
  output logic [OCC_W-1:0]        occupancy,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic [CNT_W-1:0]        stall_cnt
);
  localparam int unsigned INC_W = $clog2(2 * STAGES + 1);
  localparam int unsigned LAST  = STAGES - 1;

  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_data [STAGES];
  logic              r_empty;
  logic [OCC_W-1:0]  r_occ;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [STAGES-1:0] w_acc;
  logic [STAGES-1:0] w_move;
  logic [STAGES-1:0] w_up_valid;
  logic [STAGES-1:0] w_valid_d;
  logic [WIDTH-1:0]  w_up_data [STAGES];
  logic              w_in_ready;
  logic              w_in_fire;
  logic [INC_W-1:0]  w_drop_inc;
  logic [OCC_W-1:0]  w_occ_d;
  logic [CNT_W:0]    w_drop_sum;

  // Acceptance ripples from the output back to stage 0 through a local carry.
  always_comb begin : handshake
    logic w_dn_acc;
    w_dn_acc = bus.out_ready;
    w_acc    = '0;
    w_move   = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_move[i] = r_valid[i] & ~stall_req[i] & w_dn_acc;
      w_acc[i]  = ~stall_req[i] & (~r_valid[i] | w_move[i]);
      w_dn_acc  = w_acc[i];
    end
  end

  assign w_in_ready = w_acc[0] & ~drain;
  assign w_in_fire  = bus.in_valid & w_in_ready;

  // A word leaving a flushed stage is already counted there, so it is not handed downstream.
  always_comb begin : next_state
    w_up_valid    = '0;
    w_valid_d     = '0;
    w_drop_inc    = '0;
    w_occ_d       = '0;
    w_up_valid[0] = w_in_fire;
    w_up_data[0]  = bus.in_data;
    for (int i = 1; i < STAGES; i++) begin
      w_up_valid[i] = w_move[i-1] & ~flush[i-1];
      w_up_data[i]  = r_data[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      if (flush[i]) begin
        w_valid_d[i] = 1'b0;
      end else if (w_acc[i]) begin
        w_valid_d[i] = w_up_valid[i];
      end else begin
        w_valid_d[i] = r_valid[i];
      end
      w_drop_inc = w_drop_inc + INC_W'(flush[i] & r_valid[i])
                              + INC_W'(flush[i] & w_up_valid[i]);
      w_occ_d    = w_occ_d + OCC_W'(w_valid_d[i]);
    end
    w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W + 1)'(w_drop_inc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= '0;
      r_empty     <= 1'b1;
      r_occ       <= '0;
      r_drop_cnt  <= '0;
      r_stall_cnt <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_valid <= w_valid_d;
      r_empty <= ~|w_valid_d;
      r_occ   <= w_occ_d;
      for (int i = 0; i < STAGES; i++) begin
        if (~flush[i] & w_acc[i] & w_up_valid[i]) begin
          r_data[i] <= w_up_data[i];
        end
      end
      r_drop_cnt <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
      if (bus.in_valid & ~w_in_ready & ~&r_stall_cnt) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid[LAST] & ~stall_req[LAST];
  assign bus.out_data  = r_data[LAST];

  assign stage_valid = r_valid;
  assign empty       = r_empty;
  assign occupancy   = r_occ;
  assign drop_cnt    = r_drop_cnt;
  assign stall_cnt   = r_stall_cnt;

  for (genvar g = 0; g < STAGES; g++) begin : g_taps
    assign stage_data[g*WIDTH +: WIDTH] = r_data[g];
  end
endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain (5 stages, 32-bit payload, 8-bit counters so saturation is
// reachable quickly); expected values are written out per cycle.
module tb_pipe_chain;
  localparam int unsigned STAGES = 5;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned CNT_W  = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [STAGES-1:0]       stall_req;
  logic [STAGES-1:0]       flush;
  logic                    drain;
  logic [STAGES-1:0]       stage_valid;
  logic [STAGES*WIDTH-1:0] stage_data;
  logic                    empty;
  logic [2:0]              occupancy;
  logic [CNT_W-1:0]        drop_cnt;
  logic [CNT_W-1:0]        stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_chain_if #(.WIDTH(WIDTH)) bus ();

  pipe_chain #(
    .STAGES(STAGES),
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .stall_req  (stall_req),
    .flush      (flush),
    .drain      (drain),
    .stage_valid(stage_valid),
    .stage_data (stage_data),
    .empty      (empty),
    .occupancy  (occupancy),
    .drop_cnt   (drop_cnt),
    .stall_cnt  (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d);
    chk({tag, "_ov"}, 32'(bus.out_valid), 32'(v));
    if (v) chk({tag, "_od"}, bus.out_data, d);
  endtask

  task automatic drive(input logic iv, input logic [31:0] id, input logic ordy,
                       input logic [4:0] st, input logic [4:0] fl, input logic dr);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    stall_req     = st;
    flush         = fl;
    drain         = dr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ov"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_ir"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_occ"}, 32'(occupancy), 32'd0);
    chk({tag, "_drop"}, 32'(drop_cnt), 32'd0);
    chk({tag, "_stall"}, 32'(stall_cnt), 32'd0);
    chk({tag, "_sv"}, 32'(stage_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s_sd%0d", tag, i), stage_data[i*32 +: 32], 32'd0);
    end
  endtask

  initial begin
    logic        ev;
    logic [31:0] ed;
    int          w;

    reset = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk_reset_state("rst");

    // 1: back-to-back stream, 5-cycle latency then one word per cycle
    for (int n = 0; n < 16; n++) begin
      drive(n < 8, 32'(n + 1), 1'b1, 5'd0, 5'd0, 1'b0);
      #1;
      ev = (n >= 5 && n <= 12);
      chk_out($sformatf("t1_c%0d", n), ev, 32'(n - 4));
      tick();
    end
    chk("t1_stall_cnt", 32'(stall_cnt), 32'd0);

    // 2: fill with out_ready low, hold 3 blocked cycles, release
    for (int n = 0; n < 17; n++) begin
      w = (n < 5) ? n : ((n < 8) ? 5 : n - 3);
      drive(n <= 10, 32'h10 + 32'(w), n >= 8, 5'd0, 5'd0, 1'b0);
      #1;
      ev = (n >= 5 && n <= 15);
      ed = (n < 8) ? 32'h10 : 32'h10 + 32'(n - 8);
      chk_out($sformatf("t2_c%0d", n), ev, ed);
      if (n == 5 || n == 7) chk($sformatf("t2_ir%0d", n), 32'(bus.in_ready), 32'd0);
      if (n == 5) chk("t2_occ_full", 32'(occupancy), 32'd5);
      if (n == 8) begin
        chk("t2_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("t2_ir_release", 32'(bus.in_ready), 32'd1);
      end
      tick();
    end

    // 3: stall stage 2 for two cycles in a full stream
    for (int n = 0; n < 16; n++) begin
      w = (n < 5) ? n : ((n <= 7) ? 5 : n - 2);
      drive(n <= 9, 32'h20 + 32'(w), 1'b1, (n == 5 || n == 6) ? 5'b00100 : 5'b00000,
            5'd0, 1'b0);
      #1;
      ev = (n == 5 || n == 6 || (n >= 9 && n <= 14));
      ed = (n <= 6) ? 32'h20 + 32'(n - 5) : 32'h20 + 32'(n - 7);
      chk_out($sformatf("t3_c%0d", n), ev, ed);
      if (n == 6) chk("t3_sv_bubble", 32'(stage_valid), 32'b10111);
      if (n == 7) chk("t3_sv_drained", 32'(stage_valid), 32'b00111);
      if (n == 6 || n == 7) begin
        chk($sformatf("t3_sd0_c%0d", n), stage_data[0 +: 32], 32'h24);
        chk($sformatf("t3_sd1_c%0d", n), stage_data[32 +: 32], 32'h23);
        chk($sformatf("t3_sd2_c%0d", n), stage_data[64 +: 32], 32'h22);
      end
      tick();
    end
    chk("t3_stall_cnt", 32'(stall_cnt), 32'd5);

    // 4: flush stages 0-2 of a full chain
    for (int n = 0; n < 14; n++) begin
      w = (n < 5) ? n : n - 1;
      drive(n < 5 || n == 6 || n == 7, 32'h30 + 32'(w), 1'b1, 5'd0,
            (n == 5) ? 5'b00111 : 5'b00000, 1'b0);
      #1;
      ev = (n == 5 || n == 6 || n == 11 || n == 12);
      ed = (n <= 6) ? 32'h30 + 32'(n - 5) : 32'h30 + 32'(n - 6);
      chk_out($sformatf("t4_c%0d", n), ev, ed);
      if (n == 6) begin
        chk("t4_sv", 32'(stage_valid), 32'b10000);
        chk("t4_drop", 32'(drop_cnt), 32'd3);
        chk("t4_occ", 32'(occupancy), 32'd1);
      end
      tick();
    end

    // 5: drain a chain of 5 words, then resume
    for (int n = 0; n < 18; n++) begin
      drive(n <= 9 || n == 11, 32'h40 + 32'((n < 5) ? n : 5), n >= 5, 5'd0, 5'd0,
            n >= 5 && n <= 10);
      #1;
      ev = ((n >= 5 && n <= 9) || n == 16);
      ed = (n <= 9) ? 32'h40 + 32'(n - 5) : 32'h45;
      chk_out($sformatf("t5_c%0d", n), ev, ed);
      if (n == 5) chk("t5_ir_drain", 32'(bus.in_ready), 32'd0);
      if (n == 9) chk("t5_not_empty", 32'(empty), 32'd0);
      if (n == 10) begin
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_occ", 32'(occupancy), 32'd0);
      end
      if (n == 11) chk("t5_ir_resume", 32'(bus.in_ready), 32'd1);
      tick();
    end
    chk("t5_stall_cnt", 32'(stall_cnt), 32'd10);

    // 6: bring drop_cnt to 0xFE via discarded inputs, then saturate, then reset mid-stream
    for (int n = 0; n < 251; n++) begin
      drive(1'b1, 32'h50, 1'b1, 5'd0, 5'b00001, 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 1'b1, 5'd0, 5'd0, 1'b0);
    #1;
    chk("t6_drop_pre", 32'(drop_cnt), 32'hFE);
    chk("t6_sv_pre", 32'(stage_valid), 32'd0);
    tick();
    for (int n = 0; n < 8; n++) begin
      drive(n < 5 || n == 6, 32'h60 + 32'(n), 1'b0, (n == 5) ? 5'b00100 : 5'b00000,
            (n == 5) ? 5'b00111 : ((n == 6) ? 5'b00001 : 5'b00000), 1'b0);
      #1;
      if (n == 5) chk("t6_drop_before", 32'(drop_cnt), 32'hFE);
      if (n == 6 || n == 7) begin
        chk($sformatf("t6_drop_sat%0d", n), 32'(drop_cnt), 32'hFF);
        chk($sformatf("t6_sv%0d", n), 32'(stage_valid), 32'b11000);
      end
      tick();
    end
    reset = 1'b1;
    drive(1'b1, 32'h70, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();
    reset = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    #1;
    chk_reset_state("t6_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
